// File: rtl/i2c_dac_pkg.sv
// Shared constants for the MCP4725-style I2C write responder: state encoding,
// default target address, fast-write command bits and byte/bit widths.
package i2c_dac_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;
  localparam int CODE_W    = 12;
  localparam int PD_W      = 2;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h61;
  localparam logic [1:0] C_FAST_WRITE     = 2'b00;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_HI       = 3'd3;
  localparam logic [2:0] ST_HI_ACK   = 3'd4;
  localparam logic [2:0] ST_LO       = 3'd5;
  localparam logic [2:0] ST_LO_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_ADDR     = ST_ADDR,
    S_ADDR_ACK = ST_ADDR_ACK,
    S_HI       = ST_HI,
    S_HI_ACK   = ST_HI_ACK,
    S_LO       = ST_LO,
    S_LO_ACK   = ST_LO_ACK,
    S_IGNORE   = ST_IGNORE
  } state_t;

  // A write to us: 7-bit address matches and R/W bit is 0.
  function automatic logic is_write_to(input logic [7:0] b, input logic [6:0] addr);
    return (b[7:1] == addr) && !b[0];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer, optional 3-sample majority spike filter (DAC_RESP_FILTER_EN)
// and rise/fall strobes for one I2C line. All flops reset to 1 (idle bus).
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  always_ff @(posedge i_clk) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
  end

`ifdef DAC_RESP_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;
  logic       w_maj;

  // Two of the last three synchronized samples must agree before the level moves.
  assign w_maj = (r_sync[SYNC_STAGES-1] & r_hist[0]) |
                 (r_sync[SYNC_STAGES-1] & r_hist[1]) |
                 (r_hist[0] & r_hist[1]);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_hist <= 2'b11;
      r_filt <= 1'b1;
    end else begin
      r_hist <= {r_hist[0], r_sync[SYNC_STAGES-1]};
      r_filt <= w_maj;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge i_clk) begin
    if (reset) r_prev <= 1'b1;
    else       r_prev <= w_level;
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_dac_responder.sv
// MCP4725 fast-mode write responder: decodes address + high/low byte pairs and
// publishes the DAC code and power-down bits. Reads are NACKed. Optional line
// filter selected with DAC_RESP_FILTER_EN (see i2c_line_sync).
module i2c_dac_responder
  import i2c_dac_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        i_scl,
  inout  wire         io_sda,
  output logic [11:0] o_dac_code,
  output logic [1:0]  o_pd,
  output logic        o_valid,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .i_clk(i_clk), .reset(reset), .i_line(i_scl),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .i_clk(i_clk), .reset(reset), .i_line(io_sda),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  state_t                 r_state, w_state_nxt;
  logic [BIT_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0]      r_shift, w_shift_nxt;
  logic [BYTE_W-1:0]      r_stage, w_stage_nxt;
  logic                   r_sda_oe, w_sda_oe_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   w_commit;
  logic [BYTE_W-1:0]      w_byte;

  assign w_byte = {r_shift[BYTE_W-2:0], w_sda};

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_stage    <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      o_dac_code <= '0;
      o_pd       <= '0;
      o_valid    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_stage  <= w_stage_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
      o_valid  <= w_commit;
      if (w_commit) begin
        o_pd       <= r_stage[5:4];
        o_dac_code <= {r_stage[3:0], r_shift};
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_stage_nxt  = r_stage;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;
    w_commit     = 1'b0;
    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_cnt_nxt    = '0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR, S_HI, S_LO: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == 3'd7) begin
              if (r_state == S_ADDR) begin
                if (is_write_to(w_byte, DEV_ADDR)) begin
                  w_state_nxt = S_ADDR_ACK;
                  w_busy_nxt  = 1'b1;
                end else begin
                  w_state_nxt = S_IGNORE;
                  w_busy_nxt  = 1'b0;
                end
              end else if (r_state == S_HI) begin
                w_stage_nxt = w_byte;
                w_state_nxt = S_HI_ACK;
              end else begin
                w_state_nxt = S_LO_ACK;
              end
            end
          end
        end
        // First SCL fall after the 8th bit pulls SDA low; the next fall releases it.
        S_ADDR_ACK, S_HI_ACK, S_LO_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = '0;
              if (r_state == S_ADDR_ACK) begin
                w_state_nxt = S_HI;
              end else if (r_state == S_HI_ACK) begin
                w_state_nxt = (r_stage[7:6] == C_FAST_WRITE) ? S_LO : S_IGNORE;
              end else begin
                w_state_nxt = S_HI;
                w_commit    = 1'b1;
              end
            end
          end
        end
        S_IDLE, S_IGNORE: begin
          w_sda_oe_nxt = 1'b0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign io_sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign o_busy      = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_dac_responder.sv
// Directed bench for i2c_dac_responder: bit-banged I2C master, expected-commit
// queue checked on every o_valid pulse, and a single summary line.
module tb_i2c_dac_responder;

  localparam int Q = 20;

  localparam logic [2:0] E_IDLE   = 3'd0;
  localparam logic [2:0] E_IGNORE = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tb_scl = 1'b1;
  logic        tb_sda_low = 1'b0;
  wire         sda;
  logic [11:0] o_dac_code;
  logic [1:0]  o_pd;
  logic        o_valid;
  logic        o_busy;
  logic [2:0]  o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  logic [13:0] exp_q[$];
  logic        ack;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  i2c_dac_responder dut (
    .i_clk(clk), .reset(reset), .i_scl(tb_scl), .io_sda(sda),
    .o_dac_code(o_dac_code), .o_pd(o_pd), .o_valid(o_valid),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0; wait_clk(Q);
    tb_scl     = 1'b1; wait_clk(Q);
    tb_sda_low = 1'b1; wait_clk(Q);
    tb_scl     = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1; wait_clk(Q);
    tb_scl     = 1'b1; wait_clk(Q);
    tb_sda_low = 1'b0; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    tb_sda_low = ~b; wait_clk(Q);
    tb_scl     = 1'b1; wait_clk(2*Q);
    tb_scl     = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_bit);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tb_sda_low = 1'b0; wait_clk(Q);
    tb_scl     = 1'b1; wait_clk(Q);
    ack_bit    = sda;  wait_clk(Q);
    tb_scl     = 1'b0; wait_clk(Q);
  endtask

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      n_valid++;
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("commit_pd_code", 32'({o_pd, o_dac_code}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // Reset and idle-state checks
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    check("rst_code",  32'(o_dac_code), 32'h000);
    check("rst_pd",    32'(o_pd), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy",  32'(o_busy), 32'd0);
    check("rst_sda",   32'(sda), 32'd1);
    check("rst_state", 32'(o_dbg_state), 32'(E_IDLE));

    // Test 1: C2 07 FF -> 0x7FF pd 0
    i2c_start();
    write_byte(8'hC2, ack); check("t1_ack_addr", 32'(ack), 32'd0);
    write_byte(8'h07, ack); check("t1_ack_hi", 32'(ack), 32'd0);
    exp_q.push_back({2'd0, 12'h7FF});
    write_byte(8'hFF, ack); check("t1_ack_lo", 32'(ack), 32'd0);
    check("t1_busy", 32'(o_busy), 32'd1);
    i2c_stop();
    check("t1_busy_after_stop", 32'(o_busy), 32'd0);
    check("t1_code", 32'(o_dac_code), 32'h7FF);
    check("t1_pd",   32'(o_pd), 32'd0);
    check("t1_nvalid", 32'(n_valid), 32'd1);
    check("t1_state", 32'(o_dbg_state), 32'(E_IDLE));

    // Test 2: wrong address C4 -> NACK, IGNORE, no update
    i2c_start();
    write_byte(8'hC4, ack); check("t2_nack", 32'(ack), 32'd1);
    check("t2_state", 32'(o_dbg_state), 32'(E_IGNORE));
    check("t2_busy", 32'(o_busy), 32'd0);
    write_byte(8'h07, ack); check("t2_nack_hi", 32'(ack), 32'd1);
    write_byte(8'hFF, ack); check("t2_nack_lo", 32'(ack), 32'd1);
    i2c_stop();
    check("t2_nvalid", 32'(n_valid), 32'd1);
    check("t2_code", 32'(o_dac_code), 32'h7FF);

    // Test 3: two pairs in one transfer -> 0xABC pd 2, then 0x500 pd 0
    i2c_start();
    write_byte(8'hC2, ack); check("t3_ack_addr", 32'(ack), 32'd0);
    exp_q.push_back({2'd2, 12'hABC});
    exp_q.push_back({2'd0, 12'h500});
    write_byte(8'h2A, ack); check("t3_ack_hi1", 32'(ack), 32'd0);
    write_byte(8'hBC, ack); check("t3_ack_lo1", 32'(ack), 32'd0);
    check("t3_code1", 32'(o_dac_code), 32'hABC);
    check("t3_pd1",   32'(o_pd), 32'd2);
    write_byte(8'h05, ack); check("t3_ack_hi2", 32'(ack), 32'd0);
    write_byte(8'h00, ack); check("t3_ack_lo2", 32'(ack), 32'd0);
    i2c_stop();
    check("t3_nvalid", 32'(n_valid), 32'd3);
    check("t3_code2", 32'(o_dac_code), 32'h500);
    check("t3_pd2",   32'(o_pd), 32'd0);

    // Test 4: partial transfer, then a read is NACKed
    i2c_start();
    write_byte(8'hC2, ack); check("t4_ack_addr", 32'(ack), 32'd0);
    write_byte(8'h07, ack); check("t4_ack_hi", 32'(ack), 32'd0);
    i2c_stop();
    check("t4_nvalid", 32'(n_valid), 32'd3);
    check("t4_code", 32'(o_dac_code), 32'h500);
    i2c_start();
    write_byte(8'hC3, ack); check("t4_read_nack", 32'(ack), 32'd1);
    check("t4_read_state", 32'(o_dbg_state), 32'(E_IGNORE));
    i2c_stop();

    // Test 5: reset mid-HI byte, then a full write commits
    i2c_start();
    write_byte(8'hC2, ack); check("t5_ack_addr", 32'(ack), 32'd0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    reset = 1'b1; wait_clk(1);
    reset = 1'b0;
    check("t5_rst_code", 32'(o_dac_code), 32'h000);
    check("t5_rst_pd",   32'(o_pd), 32'd0);
    check("t5_rst_busy", 32'(o_busy), 32'd0);
    check("t5_rst_state", 32'(o_dbg_state), 32'(E_IDLE));
    wait_clk(10);
    check("t5_no_false_start", 32'(o_dbg_state), 32'(E_IDLE));
    i2c_start();
    write_byte(8'hC2, ack); check("t5_ack_addr2", 32'(ack), 32'd0);
    exp_q.push_back({2'd1, 12'h321});
    write_byte(8'h13, ack); check("t5_ack_hi", 32'(ack), 32'd0);
    write_byte(8'h21, ack); check("t5_ack_lo", 32'(ack), 32'd0);
    i2c_stop();
    check("t5_nvalid", 32'(n_valid), 32'd4);
    check("t5_code", 32'(o_dac_code), 32'h321);
    check("t5_pd",   32'(o_pd), 32'd1);

    // Test 6: C bits 01 -> ACK then IGNORE; repeated START recovers
    i2c_start();
    write_byte(8'hC2, ack); check("t6_ack_addr", 32'(ack), 32'd0);
    write_byte(8'h4F, ack); check("t6_ack_bad_c", 32'(ack), 32'd0);
    check("t6_state", 32'(o_dbg_state), 32'(E_IGNORE));
    check("t6_busy", 32'(o_busy), 32'd1);
    i2c_start();
    write_byte(8'hC2, ack); check("t6_ack_addr2", 32'(ack), 32'd0);
    exp_q.push_back({2'd0, 12'h123});
    write_byte(8'h01, ack); check("t6_ack_hi", 32'(ack), 32'd0);
    write_byte(8'h23, ack); check("t6_ack_lo", 32'(ack), 32'd0);
    i2c_stop();
    check("t6_nvalid", 32'(n_valid), 32'd5);
    check("t6_code", 32'(o_dac_code), 32'h123);
    check("t6_pd",   32'(o_pd), 32'd0);

`ifdef DAC_RESP_FILTER_EN
    // 1-clock SDA glitch with SCL high must not look like START/STOP
    tb_sda_low = 1'b1; wait_clk(1);
    tb_sda_low = 1'b0; wait_clk(20);
    check("flt_state", 32'(o_dbg_state), 32'(E_IDLE));
    check("flt_busy",  32'(o_busy), 32'd0);
`endif

    wait_clk(10);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("final_nvalid", 32'(n_valid), 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
